lsu_mem_if: RTL and testbench
=============================

Name: lsu_mem_if

Overview:
- Memory-side consumer of the controller's MemWrite[2:0] and MemtoReg[3:0] encodings.
- Accepts one load/store request at a time and issues a single word-bus transaction with a req/ack handshake.
- Returns sign- or zero-extended load data, or reports errors.
- Sits between the datapath and data memory, so data memory may have wait states.

Parameters:
- ADDR_W, 32, byte-address width
- TIMEOUT_CYCLES, 16, maximum cycles spent waiting for bus_ack (used only when LSU_TIMEOUT_EN is defined)

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high in IDLE only
- mem_write  in  3  001 sw, 010 sh, 100 sb, 000 no store
- load_type  in  4  0001 lw, 1000 lb, 1001 lh, 1010 lbu, 1100 lhu; any other value means no load
- addr  in  ADDR_W  byte address
- wdata  in  32  store data from rs2
- resp_valid  out  1  one-cycle response pulse
- resp_err  out  1  error flag, qualified by resp_valid
- resp_code  out  2  00 ok, 01 misaligned, 10 illegal encoding, 11 timeout
- rdata  out  32  extended load data; 0 for stores and errors
- bus_req  out  1  bus request, held until ack
- bus_we  out  1  write enable
- bus_be  out  4  byte enables
- bus_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  transaction complete; bus_rdata valid in the same cycle
- bus_rdata  in  32  read word

Behaviour:
- States: IDLE, BUS, RESP.
- Reset (rstn low, asynchronous):
  - State goes to IDLE.
  - All registered outputs are 0 (resp_valid, resp_err, resp_code, rdata, bus_req, bus_we, bus_be, bus_addr, bus_wdata).
  - req_ready=1.
- Reset mid-transaction: bus_req falls immediately, the transaction is abandoned, and no response is issued.
- IDLE accepts a request when req_valid=1 (accept cycle T). The request is decoded in cycle T:
  - Illegal encoding: mem_write not in {000,001,010,100}, or both a store and a load code set. Goes to RESP at T+1 with resp_code=10 and no bus activity.
  - Misaligned: lw/sw with addr[1:0]!=0, or lh/lhu/sh with addr[0]=1. Goes to RESP with resp_code=01 and no bus activity.
  - No access (mem_write=000 and load_type not a load code): goes to RESP with resp_code=00 and rdata=0.
  - Otherwise: registers bus_addr/bus_we/bus_be/bus_wdata, asserts bus_req at T+1, and goes to BUS.
- Byte enables:
  - sw/lw: 1111.
  - sh/lh/lhu: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - sb/lb/lbu: 0001 shifted left by addr[1:0].
- Write data:
  - sb: {4{wdata[7:0]}}.
  - sh: {2{wdata[15:0]}}.
  - sw: wdata.
- BUS state:
  - bus_req and all bus outputs stay stable until bus_ack.
  - On ack: bus_req drops the next cycle; the selected lane of bus_rdata is extracted and extended; then RESP.
- Load extension:
  - lb sign-extends byte addr[1:0]; lbu zero-extends it.
  - lh sign-extends half addr[1]; lhu zero-extends it.
  - lw passes the word through.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_err=(resp_code!=00).
  - Returns to IDLE; req_ready reasserts the following cycle.
  - There is no response backpressure.
- Latency:
  - Bus transaction: accept at T, earliest ack at T+1, resp_valid at T+2.
  - Error or no-access request: resp_valid at T+1.
- bus_ack outside BUS is ignored.
- req_valid while not in IDLE is ignored because req_ready=0.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - A cycle counter clears on entry to BUS and increments each BUS cycle without ack.
  - When it reaches TIMEOUT_CYCLES, bus_req drops and RESP is entered with resp_code=11 and rdata=0.
  - Ack in the same cycle as the limit wins (normal completion).
- LSU_TIMEOUT_EN undefined:
  - No counter; BUS waits indefinitely.
  - resp_code=11 is never produced.

Test Plan:
- sw addr=0x100 wdata=0xDEADBEEF, ack after 3 cycles -> bus_we=1, be=1111, bus_addr=0x100, bus_wdata=0xDEADBEEF; resp_valid once, code 00.
- sb addr=0x203 wdata=0x000000A5, ack immediately -> be=1000, bus_wdata=0xA5A5A5A5; resp_valid at T+2.
- lb addr=0x302 and lbu addr=0x302 with bus_rdata=0x12F45678 -> rdata=0xFFFFFFF4 and 0x000000F4 respectively; lh addr=0x302 -> 0x000012F4.
- lw addr=0x101 and sh addr=0x101 -> resp_code=01 at T+1, bus_req never asserted; mem_write=011 -> code 10.
- Reset pulse while in BUS -> bus_req low immediately, no resp_valid; next request completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16, lw with no ack -> bus_req high 16 cycles, then resp_code=11, rdata=0.

Source files
------------

// File: rtl/lsu_mem_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_if
//
// Load/store unit bus front end. It accepts one load or store at a time from
// the datapath, using the controller's mem_write / load_type encodings. It
// then runs a single word-wide bus transaction with a req/ack handshake, so
// data memory may insert wait states. It returns either extended load data or
// an error code as a one-cycle response pulse.
//
// Optional feature macro:
//   LSU_TIMEOUT_EN - when defined, a BUS-state watchdog abandons a transaction
//                    after TIMEOUT_CYCLES cycles without bus_ack and responds
//                    with resp_code=11. When undefined, BUS waits forever.
//
// Parameters:
//   ADDR_W          byte-address width
//   TIMEOUT_CYCLES  ack wait limit (only meaningful with LSU_TIMEOUT_EN)
//
// Ports:
//   clk, rstn                  clock (rising edge), async active-low reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   mem_write                  001 sw, 010 sh, 100 sb, 000 no store
//   load_type                  0001 lw, 1000 lb, 1001 lh, 1010 lbu, 1100 lhu
//   addr, wdata                byte address and store data (rs2)
//   resp_valid                 one-cycle response pulse
//   resp_err, resp_code        00 ok, 01 misaligned, 10 illegal, 11 timeout
//   rdata                      extended load data (0 for stores/errors)
//   bus_req/we/be/addr/wdata   word-bus request, held stable until bus_ack
//   bus_ack, bus_rdata         completion strobe and read word (same cycle)
// ---------------------------------------------------------------------------
module lsu_mem_if #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        mem_write,
    input  logic [3:0]        load_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [1:0]        resp_code,
    output logic [31:0]       rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] RC_OK    = 2'b00;
    localparam logic [1:0] RC_MISAL = 2'b01;
    localparam logic [1:0] RC_ILL   = 2'b10;
`ifdef LSU_TIMEOUT_EN
    localparam logic [1:0] RC_TMO   = 2'b11;
`endif

    // Internal load kind, kept across the BUS state to pick and extend the lane.
    localparam logic [2:0] K_NONE = 3'd0;
    localparam logic [2:0] K_LW   = 3'd1;
    localparam logic [2:0] K_LB   = 3'd2;
    localparam logic [2:0] K_LBU  = 3'd3;
    localparam logic [2:0] K_LH   = 3'd4;
    localparam logic [2:0] K_LHU  = 3'd5;

    logic [1:0] state;
    logic [2:0] kind_q;
    logic [1:0] off_q;

    // ------------------------------------------------------------------
    // Request decode. This is evaluated every cycle and used only on accept.
    // ------------------------------------------------------------------
    logic        d_mw_ok, d_st_w, d_st_h, d_st_b, d_store, d_load;
    logic        d_word, d_half, d_byte, d_illegal, d_misal;
    logic [2:0]  d_kind;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        d_mw_ok = 1'b1;
        d_st_w  = 1'b0;
        d_st_h  = 1'b0;
        d_st_b  = 1'b0;
        d_kind  = K_NONE;
        d_be    = 4'b0000;
        d_wdata = wdata;

        case (mem_write)
            3'b000:  ;
            3'b001:  d_st_w = 1'b1;
            3'b010:  d_st_h = 1'b1;
            3'b100:  d_st_b = 1'b1;
            default: d_mw_ok = 1'b0;
        endcase

        case (load_type)
            4'b0001: d_kind = K_LW;
            4'b1000: d_kind = K_LB;
            4'b1001: d_kind = K_LH;
            4'b1010: d_kind = K_LBU;
            4'b1100: d_kind = K_LHU;
            default: d_kind = K_NONE;
        endcase

        d_store = d_st_w | d_st_h | d_st_b;
        d_load  = (d_kind != K_NONE);
        d_word  = d_st_w | (d_kind == K_LW);
        d_half  = d_st_h | (d_kind == K_LH) | (d_kind == K_LHU);
        d_byte  = d_st_b | (d_kind == K_LB) | (d_kind == K_LBU);

        d_illegal = !d_mw_ok || (d_store && d_load);
        d_misal   = (d_word && (addr[1:0] != 2'b00)) || (d_half && addr[0]);

        if (d_word)      d_be = 4'b1111;
        else if (d_half) d_be = addr[1] ? 4'b1100 : 4'b0011;
        else if (d_byte) d_be = 4'b0001 << addr[1:0];

        // Replicate narrow store data on every lane; bus_be selects the lane.
        if (d_st_b)      d_wdata = {4{wdata[7:0]}};
        else if (d_st_h) d_wdata = {2{wdata[15:0]}};
    end

    // Pick the addressed lane of the read word and extend it.
    function automatic logic [31:0] extend_load(input logic [31:0] w,
                                                input logic [1:0]  off,
                                                input logic [2:0]  kind);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (kind)
            K_LW:    extend_load = w;
            K_LB:    extend_load = {{24{b[7]}}, b};
            K_LBU:   extend_load = {24'h0, b};
            K_LH:    extend_load = {{16{h[15]}}, h};
            K_LHU:   extend_load = {16'h0, h};
            default: extend_load = 32'h0;
        endcase
    endfunction

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             tmo_hit;
    // The limit is reached when the count would become TIMEOUT_CYCLES.
    assign tmo_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    assign req_ready = (state == S_IDLE);

    // ------------------------------------------------------------------
    // Control FSM and registered outputs.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            kind_q     <= K_NONE;
            off_q      <= 2'b00;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_code  <= RC_OK;
            rdata      <= 32'h0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_be     <= 4'b0000;
            bus_addr   <= '0;
            bus_wdata  <= 32'h0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (d_illegal) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_code  <= RC_ILL;
                            rdata      <= 32'h0;
                        end else if (d_misal) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_code  <= RC_MISAL;
                            rdata      <= 32'h0;
                        end else if (!d_store && !d_load) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_code  <= RC_OK;
                            rdata      <= 32'h0;
                        end else begin
                            state     <= S_BUS;
                            bus_req   <= 1'b1;
                            bus_we    <= d_store;
                            bus_be    <= d_be;
                            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            bus_wdata <= d_store ? d_wdata : 32'h0;
                            kind_q    <= d_kind;
                            off_q     <= addr[1:0];
`ifdef LSU_TIMEOUT_EN
                            wait_cnt  <= '0;
`endif
                        end
                    end
                end

                S_BUS: begin
                    // An ack in the limit cycle takes priority over the timeout.
                    if (bus_ack) begin
                        state      <= S_RESP;
                        bus_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_code  <= RC_OK;
                        rdata      <= extend_load(bus_rdata, off_q, kind_q);
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state      <= S_RESP;
                        bus_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_code  <= RC_TMO;
                        rdata      <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                S_RESP: begin
                    state      <= S_IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_code  <= RC_OK;
                    rdata      <= 32'h0;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_if
//
// Directed self-checking bench for lsu_mem_if. Inputs change 1 time unit after
// the rising edge, and outputs are sampled at that same point. The bench does
// not wait on any DUT event. Every step has a fixed cycle count.
// ---------------------------------------------------------------------------
module tb_lsu_mem_if;

    localparam int ADDR_W = 32;
    localparam int TMO    = 16;

    logic              clk;
    logic              rstn;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        mem_write;
    logic [3:0]        load_type;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [1:0]        resp_code;
    logic [31:0]       rdata;
    logic              bus_req;
    logic              bus_we;
    logic [3:0]        bus_be;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    lsu_mem_if #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_write  (mem_write),
        .load_type  (load_type),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_code  (resp_code),
        .rdata      (rdata),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_be     (bus_be),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int resp_cnt = 0;

    // Count response pulses at the falling edge, away from the active edge.
    always @(negedge clk) if (resp_valid === 1'b1) resp_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle (cycle T). Return in cycle T+1.
    task automatic issue(input logic [2:0] mw, input logic [3:0] lt,
                         input logic [31:0] a, input logic [31:0] wd);
        mem_write = mw;
        load_type = lt;
        addr      = a;
        wdata     = wd;
        req_valid = 1'b1;
        check("req_ready_at_accept", req_ready, 1);
        tick();
        req_valid = 1'b0;
        mem_write = 3'b000;
        load_type = 4'b0000;
    endtask

    // Complete a load with an immediate ack. The response is due at T+2.
    task automatic do_load(input string tag, input logic [3:0] lt, input logic [31:0] a,
                           input logic [31:0] word, input logic [3:0] exp_be,
                           input logic [31:0] exp_addr, input logic [31:0] exp_rdata);
        issue(3'b000, lt, a, 32'h0);
        check({tag, "_bus_req"}, bus_req, 1);
        check({tag, "_bus_we"}, bus_we, 0);
        check({tag, "_bus_be"}, bus_be, exp_be);
        check({tag, "_bus_addr"}, bus_addr, exp_addr);
        bus_ack   = 1'b1;
        bus_rdata = word;
        tick();
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        check({tag, "_resp_valid"}, resp_valid, 1);
        check({tag, "_resp_code"}, resp_code, 0);
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_bus_req_drop"}, bus_req, 0);
        tick();
        check({tag, "_resp_once"}, resp_valid, 0);
        check({tag, "_ready_back"}, req_ready, 1);
    endtask

    // A request that never reaches the bus. The response is due at T+1.
    task automatic do_nobus(input string tag, input logic [2:0] mw, input logic [3:0] lt,
                            input logic [31:0] a, input logic [1:0] exp_code);
        issue(mw, lt, a, 32'h1234_5678);
        check({tag, "_resp_valid"}, resp_valid, 1);
        check({tag, "_resp_code"}, resp_code, exp_code);
        check({tag, "_resp_err"}, resp_err, (exp_code != 2'b00));
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_no_bus_req"}, bus_req, 0);
        tick();
        check({tag, "_resp_once"}, resp_valid, 0);
        check({tag, "_no_bus_req2"}, bus_req, 0);
        check({tag, "_ready_back"}, req_ready, 1);
    endtask

    initial begin
        int r0;
        rstn      = 1'b0;
        req_valid = 1'b0;
        mem_write = 3'b000;
        load_type = 4'b0000;
        addr      = '0;
        wdata     = 32'h0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;

        // ---- reset state ----
        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_code", resp_code, 0);
        check("rst_rdata", rdata, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_be", bus_be, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        rstn = 1'b1;
        tick();

        // bus_ack outside BUS must be ignored
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("idle_ack_no_resp", resp_valid, 0);
        check("idle_ack_ready", req_ready, 1);

        // ---- sw 0x100, ack after 3 cycles ----
        r0 = resp_cnt;
        issue(3'b001, 4'b0000, 32'h100, 32'hDEAD_BEEF);
        check("sw_bus_req", bus_req, 1);
        check("sw_bus_we", bus_we, 1);
        check("sw_bus_be", bus_be, 4'b1111);
        check("sw_bus_addr", bus_addr, 32'h100);
        check("sw_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
        check("sw_ready_busy", req_ready, 0);
        // A request while busy must be ignored.
        req_valid = 1'b1;
        mem_write = 3'b100;
        addr      = 32'h0;
        tick();
        req_valid = 1'b0;
        mem_write = 3'b000;
        check("sw_hold_req", bus_req, 1);
        check("sw_hold_be", bus_be, 4'b1111);
        tick();
        check("sw_hold_addr", bus_addr, 32'h100);
        check("sw_hold_wdata", bus_wdata, 32'hDEAD_BEEF);
        check("sw_no_early_resp", resp_valid, 0);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("sw_resp_valid", resp_valid, 1);
        check("sw_resp_code", resp_code, 0);
        check("sw_resp_err", resp_err, 0);
        check("sw_rdata", rdata, 0);
        check("sw_bus_req_drop", bus_req, 0);
        tick();
        check("sw_resp_once", resp_valid, 0);
        check("sw_ready_back", req_ready, 1);
        check("sw_resp_count", resp_cnt - r0, 1);

        // ---- sb 0x203, immediate ack ----
        issue(3'b100, 4'b0000, 32'h203, 32'h0000_00A5);
        check("sb_bus_be", bus_be, 4'b1000);
        check("sb_bus_wdata", bus_wdata, 32'hA5A5_A5A5);
        check("sb_bus_addr", bus_addr, 32'h200);
        check("sb_bus_we", bus_we, 1);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("sb_resp_t2", resp_valid, 1);
        check("sb_resp_code", resp_code, 0);
        tick();

        // ---- sh 0x102 ----
        issue(3'b010, 4'b0000, 32'h102, 32'h0000_BEEF);
        check("sh_bus_be", bus_be, 4'b1100);
        check("sh_bus_wdata", bus_wdata, 32'hBEEF_BEEF);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("sh_resp", resp_valid, 1);
        tick();

        // ---- loads with lane extraction ----
        do_load("lb",  4'b1000, 32'h302, 32'h12F4_5678, 4'b0100, 32'h300, 32'hFFFF_FFF4);
        do_load("lbu", 4'b1010, 32'h302, 32'h12F4_5678, 4'b0100, 32'h300, 32'h0000_00F4);
        do_load("lh",  4'b1001, 32'h302, 32'h12F4_5678, 4'b1100, 32'h300, 32'h0000_12F4);
        do_load("lh0", 4'b1001, 32'h300, 32'h1234_8765, 4'b0011, 32'h300, 32'hFFFF_8765);
        do_load("lhu", 4'b1100, 32'h300, 32'h1234_8765, 4'b0011, 32'h300, 32'h0000_8765);
        do_load("lb1", 4'b1000, 32'h301, 32'h0000_7F00, 4'b0010, 32'h300, 32'h0000_007F);
        do_load("lw",  4'b0001, 32'h104, 32'hCAFE_F00D, 4'b1111, 32'h104, 32'hCAFE_F00D);

        // ---- misaligned / illegal / no access ----
        do_nobus("lw_mis",   3'b000, 4'b0001, 32'h101, 2'b01);
        do_nobus("sh_mis",   3'b010, 4'b0000, 32'h101, 2'b01);
        do_nobus("lhu_mis",  3'b000, 4'b1100, 32'h303, 2'b01);
        do_nobus("sw_mis",   3'b001, 4'b0000, 32'h102, 2'b01);
        do_nobus("mw_011",   3'b011, 4'b0000, 32'h100, 2'b10);
        do_nobus("st_and_ld",3'b001, 4'b0001, 32'h100, 2'b10);
        do_nobus("ill_mis",  3'b111, 4'b0000, 32'h101, 2'b10);
        do_nobus("no_access",3'b000, 4'b0011, 32'h100, 2'b00);

        // ---- reset in the middle of a BUS transaction ----
        r0 = resp_cnt;
        issue(3'b000, 4'b0001, 32'h108, 32'h0);
        check("rst_mid_bus_req", bus_req, 1);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_req_drop", bus_req, 0);
        check("rst_mid_ready", req_ready, 1);
        #4 rstn = 1'b1;
        bus_ack = 1'b1;   // a late ack after reset must not produce a response
        tick();
        bus_ack = 1'b0;
        tick();
        check("rst_mid_no_resp", resp_cnt - r0, 0);
        do_load("post_rst", 4'b0001, 32'h108, 32'h0BAD_F00D, 4'b1111, 32'h108, 32'h0BAD_F00D);

`ifdef LSU_TIMEOUT_EN
        // ---- timeout with no ack ----
        issue(3'b000, 4'b0001, 32'h10C, 32'h0);
        for (int i = 1; i <= TMO; i++) begin
            check($sformatf("tmo_req_c%0d", i), bus_req, 1);
            check($sformatf("tmo_noresp_c%0d", i), resp_valid, 0);
            tick();
        end
        check("tmo_req_drop", bus_req, 0);
        check("tmo_resp_valid", resp_valid, 1);
        check("tmo_resp_code", resp_code, 2'b11);
        check("tmo_resp_err", resp_err, 1);
        check("tmo_rdata", rdata, 0);
        tick();

        // ---- ack in the limit cycle wins ----
        issue(3'b000, 4'b0001, 32'h110, 32'h0);
        for (int i = 1; i < TMO; i++) tick();
        check("lim_req_still", bus_req, 1);
        bus_ack   = 1'b1;
        bus_rdata = 32'h1357_9BDF;
        tick();
        bus_ack   = 1'b0;
        check("lim_resp_valid", resp_valid, 1);
        check("lim_resp_code", resp_code, 0);
        check("lim_rdata", rdata, 32'h1357_9BDF);
        tick();
`else
        // ---- without the watchdog BUS waits indefinitely ----
        r0 = resp_cnt;
        issue(3'b000, 4'b0001, 32'h10C, 32'h0);
        for (int i = 0; i < TMO + 8; i++) tick();
        check("nto_req_held", bus_req, 1);
        check("nto_no_resp", resp_cnt - r0, 0);
        bus_ack   = 1'b1;
        bus_rdata = 32'h2468_ACE0;
        tick();
        bus_ack   = 1'b0;
        check("nto_resp_valid", resp_valid, 1);
        check("nto_resp_code", resp_code, 0);
        check("nto_rdata", rdata, 32'h2468_ACE0);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
